// File: rtl/ram_arbiter_if.sv
// Port bundle for the two-port RAM arbiter: instruction requester, data requester and RAM.
// The slave modport is the arbiter's view; master is the requester/RAM environment.
interface ram_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic [31:0] i_rdata;
  logic        i_rvalid;
  logic        i_fault;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic        d_fault;

  logic        ram_req;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_rvalid;
  logic        ram_fault;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    input  ram_rdata, ram_rvalid, ram_fault,
    output i_gnt, i_rdata, i_rvalid, i_fault,
    output d_gnt, d_rdata, d_rvalid, d_fault,
    output ram_req, ram_we, ram_be, ram_addr, ram_wdata
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_be, d_addr, d_wdata,
    output ram_rdata, ram_rvalid, ram_fault,
    input  i_gnt, i_rdata, i_rvalid, i_fault,
    input  d_gnt, d_rdata, d_rvalid, d_fault,
    input  ram_req, ram_we, ram_be, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one pipelined RAM between an instruction and a data port.
// A {valid, owner} tag pipeline of LATENCY stages routes each RAM response back to its port.
module ram_arbiter #(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_arbiter_if.slave     bus,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic             resp_err
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic               contend;
  logic               rr_d;      // 1: data port wins the next contended cycle
  logic               i_gnt;
  logic               d_gnt;
  logic               ram_req;
  logic [LATENCY-1:0] vld_p;
  logic [LATENCY-1:0] own_p;     // 1: data port owns the tag
  logic               dlv;
  logic               i_dlv;
  logic               d_dlv;
  logic [31:0]        i_rdata_q;
  logic [31:0]        d_rdata_q;

  assign contend = bus.i_req & bus.d_req;
  assign i_gnt   = rst_n & bus.i_req & (~bus.d_req | ~rr_d);
  assign d_gnt   = rst_n & bus.d_req & (~bus.i_req | rr_d);
  assign ram_req = i_gnt | d_gnt;

  assign bus.i_gnt   = i_gnt;
  assign bus.d_gnt   = d_gnt;
  assign bus.ram_req = ram_req;
  assign bus.i_fault = i_gnt & bus.ram_fault;
  assign bus.d_fault = d_gnt & bus.ram_fault;

  always_comb begin
    bus.ram_we    = 1'b0;
    bus.ram_be    = 4'h0;
    bus.ram_addr  = 32'h0;
    bus.ram_wdata = 32'h0;
    if (d_gnt) begin
      bus.ram_we    = bus.d_we;
      bus.ram_be    = bus.d_be;
      bus.ram_addr  = bus.d_addr;
      bus.ram_wdata = bus.d_wdata;
    end else if (i_gnt) begin
      bus.ram_be    = 4'hF;
      bus.ram_addr  = bus.i_addr;
    end
  end

  // Response stage: a response is forwarded only when the last tag expects one.
  assign dlv   = bus.ram_rvalid & vld_p[LATENCY-1];
  assign i_dlv = dlv & ~own_p[LATENCY-1];
  assign d_dlv = dlv &  own_p[LATENCY-1];

  assign bus.i_rvalid = i_dlv;
  assign bus.d_rvalid = d_dlv;
  assign bus.i_rdata  = i_dlv ? bus.ram_rdata : i_rdata_q;
  assign bus.d_rdata  = d_dlv ? bus.ram_rdata : d_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_d         <= 1'b1;
      conflict_cnt <= '0;
      resp_err     <= 1'b0;
      vld_p        <= '0;
      i_rdata_q    <= 32'h0;
      d_rdata_q    <= 32'h0;
    end else begin
      if (contend) begin
        rr_d         <= ~rr_d;
        conflict_cnt <= sat_inc(conflict_cnt);
      end
      if (bus.ram_rvalid != vld_p[LATENCY-1])
        resp_err <= 1'b1;
      vld_p[0] <= ram_req & ~bus.ram_fault;
      for (int k = 1; k < LATENCY; k++)
        vld_p[k] <= vld_p[k-1];
      if (i_dlv)
        i_rdata_q <= bus.ram_rdata;
      if (d_dlv)
        d_rdata_q <= bus.ram_rdata;
    end
  end

  // Owner bits are meaningless while their valid bit is clear, so they carry no reset.
  always_ff @(posedge clk) begin
    own_p[0] <= d_gnt;
    for (int k = 1; k < LATENCY; k++)
      own_p[k] <= own_p[k-1];
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a RAM environment plus a transaction-level reference model
// (last contention winner, pending-response queue, saturating count) checked every cycle.
module tb_ram_arbiter;
  localparam int          LAT       = 2;
  localparam int          CW        = 4;
  localparam int          WORDS     = 64;
  localparam int          CNT_MAX   = (1 << CW) - 1;
  localparam logic [31:0] RAM_BYTES = 32'(WORDS * 4);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] conflict_cnt;
  logic          resp_err;

  ram_arbiter_if bus();

  ram_arbiter #(.LATENCY(LAT), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .conflict_cnt (conflict_cnt),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  assign bus.ram_fault = bus.ram_req && (bus.ram_addr >= RAM_BYTES);

  typedef struct {
    int          due;
    bit          own_d;
    logic [31:0] data;
  } resp_t;

  logic [31:0] mem [WORDS];
  resp_t       pend[$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  bit          i_want, d_want, d_we_v, inject, rel;
  logic [3:0]  d_be_v;
  logic [31:0] i_a, d_a, d_wd;
  bit          last_d;
  int          cnt_m;
  bit          err_m;
  logic [31:0] i_last, d_last;
  bit          obs_ig, obs_dg;
  logic [3:0]  gpat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    return (32'($urandom_range(0, 71)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic tick();
    bit          resp_now, both, ig, dg, we, flt, i_rv, d_rv;
    logic [3:0]  be;
    logic [31:0] addr, wd, word;
    @(negedge clk);
    if (rel) begin
      rst_n = 1'b1;
      rel   = 1'b0;
    end
    resp_now = rst_n && pend.size() > 0 && pend[0].due == cyc;
    bus.i_req      = i_want;
    bus.i_addr     = i_a;
    bus.d_req      = d_want;
    bus.d_we       = d_we_v;
    bus.d_be       = d_be_v;
    bus.d_addr     = d_a;
    bus.d_wdata    = d_wd;
    bus.ram_rvalid = resp_now || inject;
    bus.ram_rdata  = resp_now ? pend[0].data : $urandom();
    #1;
    both = i_want && d_want;
    ig = 1'b0;
    dg = 1'b0;
    if (rst_n) begin
      if (both) begin
        if (last_d) ig = 1'b1;
        else        dg = 1'b1;
      end else begin
        ig = i_want;
        dg = d_want;
      end
    end
    we = 1'b0; be = 4'h0; addr = 32'h0; wd = 32'h0;
    if (dg) begin
      we = d_we_v; be = d_be_v; addr = d_a; wd = d_wd;
    end else if (ig) begin
      be = 4'hF; addr = i_a;
    end
    flt  = (ig || dg) && (addr >= RAM_BYTES);
    i_rv = resp_now && !pend[0].own_d;
    d_rv = resp_now &&  pend[0].own_d;
    if (i_rv) i_last = pend[0].data;
    if (d_rv) d_last = pend[0].data;

    check("i_gnt",     32'(bus.i_gnt),     32'(ig));
    check("d_gnt",     32'(bus.d_gnt),     32'(dg));
    check("ram_req",   32'(bus.ram_req),   32'(ig || dg));
    check("ram_we",    32'(bus.ram_we),    32'(we));
    check("ram_be",    32'(bus.ram_be),    32'(be));
    check("ram_addr",  bus.ram_addr,       addr);
    check("ram_wdata", bus.ram_wdata,      wd);
    check("i_fault",   32'(bus.i_fault),   32'(ig && flt));
    check("d_fault",   32'(bus.d_fault),   32'(dg && flt));
    check("i_rvalid",  32'(bus.i_rvalid),  32'(i_rv));
    check("d_rvalid",  32'(bus.d_rvalid),  32'(d_rv));
    check("i_rdata",   bus.i_rdata,        i_last);
    check("d_rdata",   bus.d_rdata,        d_last);
    check("cnt",       32'(conflict_cnt),  32'(cnt_m));
    check("resp_err",  32'(resp_err),      32'(err_m));
    obs_ig = bus.i_gnt;
    obs_dg = bus.d_gnt;

    if (rst_n) begin
      if (both) begin
        if (cnt_m < CNT_MAX) cnt_m++;
        last_d = dg;
      end
      if (inject && !resp_now) err_m = 1'b1;
      if (resp_now) void'(pend.pop_front());
      if ((ig || dg) && !flt) begin
        word = mem[addr[7:2]];
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) word[8*b +: 8] = wd[8*b +: 8];
          mem[addr[7:2]] = word;
        end
        pend.push_back('{due: cyc + LAT, own_d: dg, data: word});
      end
      if (ig) i_want = 1'b0;
      if (dg) d_want = 1'b0;
    end
    cyc++;
  endtask

  task automatic do_reset(input string tag, input bit hold);
    rst_n = 1'b0;
    #1;
    check({tag, " gnt"},    32'({bus.i_gnt, bus.d_gnt, bus.ram_req}), 32'h0);
    check({tag, " rvalid"}, 32'({bus.i_rvalid, bus.d_rvalid}),        32'h0);
    check({tag, " i_rdata"}, bus.i_rdata, 32'h0);
    check({tag, " d_rdata"}, bus.d_rdata, 32'h0);
    check({tag, " cnt"},    32'(conflict_cnt), 32'h0);
    check({tag, " err"},    32'(resp_err),     32'h0);
    pend.delete();
    last_d = 1'b0;
    cnt_m  = 0;
    err_m  = 1'b0;
    i_last = 32'h0;
    d_last = 32'h0;
    inject = 1'b0;
    i_want = hold;
    i_a    = 32'h18;
    d_want = hold;
    d_we_v = 1'b0;
    d_a    = 32'h1C;
    repeat (2) tick();
    rel = 1'b1;
  endtask

  task automatic arm_random();
    if (!i_want && $urandom_range(0, 2) != 0) begin
      i_want = 1'b1;
      i_a    = rnd_addr();
    end
    if (!d_want && $urandom_range(0, 2) != 0) begin
      d_want = 1'b1;
      d_we_v = 1'($urandom_range(0, 1));
      d_be_v = 4'($urandom_range(0, 15));
      d_a    = rnd_addr();
      d_wd   = $urandom();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    rel = 1'b0; inject = 1'b0;
    i_want = 1'b0; d_want = 1'b0; d_we_v = 1'b0;
    d_be_v = 4'h0; i_a = 32'h0; d_a = 32'h0; d_wd = 32'h0;
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0;
    bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    bus.ram_rvalid = 1'b0; bus.ram_rdata = 32'h0;
    for (int w = 0; w < WORDS; w++) mem[w] = $urandom();
    #1;
    do_reset("por", 1'b0);

    // Single instruction read
    mem[4] = 32'hDEADBEEF;
    i_want = 1'b1; i_a = 32'h10;
    tick();
    check("033 i_gnt", 32'(obs_ig), 32'h1);
    repeat (LAT) tick();
    check("033 i_rvalid", 32'(bus.i_rvalid), 32'h1);
    check("033 i_rdata", bus.i_rdata, 32'hDEADBEEF);
    tick();

    // Contention: both held for four cycles
    do_reset("r034", 1'b0);
    gpat = 4'h0;
    for (int k = 0; k < 4; k++) begin
      if (!i_want) begin i_want = 1'b1; i_a = 32'(k * 4); end
      if (!d_want) begin d_want = 1'b1; d_we_v = 1'b0; d_a = 32'(64 + k * 4); end
      tick();
      gpat = {gpat[2:0], obs_dg};
    end
    check("034 order", 32'(gpat), 32'hA);
    i_want = 1'b0; d_want = 1'b0;
    tick();
    check("034 cnt", 32'(conflict_cnt), 32'h4);
    repeat (LAT) tick();

    // Byte write then read-back
    mem[8] = 32'h11223344;
    d_want = 1'b1; d_we_v = 1'b1; d_be_v = 4'b0010; d_a = 32'h20; d_wd = 32'h0000AB00;
    tick();
    repeat (LAT) tick();
    check("035 d_rvalid", 32'(bus.d_rvalid), 32'h1);
    i_want = 1'b1; i_a = 32'h20;
    tick();
    repeat (LAT) tick();
    check("035 i_rdata", bus.i_rdata, 32'h1122AB44);

    // Faulted access followed by a good one
    d_want = 1'b1; d_we_v = 1'b0; d_a = 32'h400;
    tick();
    check("036 d_fault", 32'(bus.d_fault), 32'h1);
    d_want = 1'b1; d_a = 32'h24;
    tick();
    repeat (LAT) tick();
    check("036 d_rvalid", 32'(bus.d_rvalid), 32'h1);
    tick();
    check("036 resp_err", 32'(resp_err), 32'h0);

    // Randomized traffic
    repeat (400) begin
      arm_random();
      tick();
    end
    repeat (LAT + 4) tick();

    // Saturation and sticky error
    do_reset("r037", 1'b0);
    repeat (20) begin
      if (!i_want) begin i_want = 1'b1; i_a = rnd_addr(); end
      if (!d_want) begin d_want = 1'b1; d_we_v = 1'b0; d_a = rnd_addr(); end
      tick();
    end
    i_want = 1'b0; d_want = 1'b0;
    tick();
    check("037 cnt", 32'(conflict_cnt), 32'hF);
    repeat (LAT + 1) tick();
    inject = 1'b1;
    tick();
    inject = 1'b0;
    repeat (3) tick();
    check("037 resp_err", 32'(resp_err), 32'h1);

    // Reset with reads in flight
    do_reset("r037b", 1'b0);
    i_want = 1'b1; i_a = 32'h10;
    tick();
    i_want = 1'b1; i_a = 32'h14;
    tick();
    do_reset("r038", 1'b1);
    tick();
    check("038 d first", 32'(obs_dg), 32'h1);
    repeat (LAT + 3) tick();
    check("038 resp_err", 32'(resp_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
